// File: rtl/proc_pkg.sv
// Shared processor-datapath types: default word width, word type and the
// two-state read-output encoding used by the register bank.
package proc_pkg;

    localparam int WIDTH_DEFAULT    = 16;
    localparam int NUM_REGS_DEFAULT = 8;

    typedef logic [15:0] word_t;

    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_FULL  = 1'b1
    } rd_state_e;

endpackage : proc_pkg

// File: rtl/register_n.sv
// Single-word loadable register with asynchronous active-high clear.
// Holds its value whenever i_load is low.
module register_n #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : register_n

// File: rtl/reg_bank_reader.sv
// Register bank with a never-stalling write port and a one-deep,
// valid/ready handshaked read port driving a registered datapath bus.
module reg_bank_reader
    import proc_pkg::*;
#(
    parameter int  WIDTH    = WIDTH_DEFAULT,
    parameter int  NUM_REGS = NUM_REGS_DEFAULT,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_req_ready,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              rd_ready,
    output logic [WIDTH-1:0]  bus_out
);

    logic              w_rst;
    logic [WIDTH-1:0]  w_regs [NUM_REGS];
    logic              w_accept;
    logic              w_bypass;
    logic [WIDTH-1:0]  w_rd_word;

    rd_state_e         r_state;
    logic              r_rd_valid;
    logic [WIDTH-1:0]  r_rd_data;
    logic [WIDTH-1:0]  r_bus_out;

    // Storage registers clear asynchronously on the active-high form of rst_n.
    assign w_rst = ~rst_n;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic w_load;
            assign w_load = wr_en && (wr_addr == ADDR_W'(gi));

            register_n #(
                .N (WIDTH)
            ) u_reg (
                .clk    (clk),
                .rst    (w_rst),
                .i_load (w_load),
                .i_d    (wr_data),
                .o_q    (w_regs[gi])
            );
        end
    endgenerate

    assign rd_req_ready = !r_rd_valid || rd_ready;
    assign w_accept     = rd_req && rd_req_ready;

    // A same-edge write to the read address wins, so the reader never sees stale data.
    assign w_bypass  = wr_en && (wr_addr == rd_addr);
    assign w_rd_word = w_bypass ? wr_data : w_regs[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RD_EMPTY;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_bus_out  <= '0;
        end else begin
            case (r_state)
                RD_EMPTY: begin
                    if (w_accept) begin
                        r_state    <= RD_FULL;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= w_rd_word;
                        r_bus_out  <= w_rd_word;
                    end
                end
                RD_FULL: begin
                    if (rd_ready) begin
                        if (w_accept) begin
                            r_rd_data <= w_rd_word;
                            r_bus_out <= w_rd_word;
                        end else begin
                            // rd_data keeps the consumed word; only the bus is blanked.
                            r_state    <= RD_EMPTY;
                            r_rd_valid <= 1'b0;
                            r_bus_out  <= '0;
                        end
                    end
                end
                default: begin
                    r_state    <= RD_EMPTY;
                    r_rd_valid <= 1'b0;
                    r_bus_out  <= '0;
                end
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign bus_out  = r_bus_out;

endmodule : reg_bank_reader
